sb_rx_packet_decoder: RTL and testbench

Sideband receive-path packet decoder for the UCIe PHY link-training sideband, the receive-side counterpart of the sideband TX path. It accepts 64-bit words from the sideband deserializer, detects the SBINIT clock pattern, and reassembles header and optional data words into decoded messages. Parity and opcode checks are applied, and the data phase is covered by a timeout. Decoded fields and pulses feed the link-training FSMs and the TX-side handshake inputs (`i_rx_sb_pattern_samp_done`).

---
 rtl/sb_rx_pkg.sv | 36 +++
 rtl/sb_rx_pattern_detector.sv | 46 ++++
 rtl/sb_rx_packet_decoder.sv | 152 +++++++++++++++
 tb/tb_sb_rx_packet_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_rx_pkg.sv
// Shared constants, field positions and types for the sideband RX packet decoder.
package sb_rx_pkg;

  localparam logic [4:0]  OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0]  OPC_MSG_DATA   = 5'b11011;
  localparam logic [63:0] PATTERN_WORD   = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam int unsigned OPC_LSB     = 0;
  localparam int unsigned OPC_MSB     = 4;
  localparam int unsigned MSGCODE_LSB = 14;
  localparam int unsigned MSGCODE_MSB = 21;
  localparam int unsigned SUBCODE_LSB = 32;
  localparam int unsigned SUBCODE_MSB = 39;
  localparam int unsigned INFO_LSB    = 40;
  localparam int unsigned INFO_MSB    = 55;
  localparam int unsigned DP_BIT      = 62;
  localparam int unsigned CP_BIT      = 63;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'b00,
    ERR_CP      = 2'b01,
    ERR_DP      = 2'b10,
    ERR_OPC     = 2'b11
  } err_code_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } rx_state_t;

  // CP covers every header bit below DP.
  function automatic logic hdr_cp_ok(input logic [63:0] hdr);
    return hdr[CP_BIT] == ^hdr[DP_BIT-1:0];
  endfunction

endpackage

// File: rtl/sb_rx_pattern_detector.sv
// Counts consecutive SBINIT clock-pattern words; done once PATTERN_CNT are seen.
module sb_rx_pattern_detector
  import sb_rx_pkg::*;
#(
  parameter int unsigned PATTERN_CNT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        valid_i,
  input  logic [63:0] data_i,
  output logic        done_o
);

  localparam int unsigned      CNT_W   = $clog2(PATTERN_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PATTERN_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      if (data_i != PATTERN_WORD) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == CNT_MAX);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/sb_rx_packet_decoder.sv
// Sideband RX decoder: reassembles header/data words into messages with parity,
// opcode and data-phase timeout checks; SBINIT pattern detect in a sub-module.
module sb_rx_packet_decoder
  import sb_rx_pkg::*;
#(
  parameter int unsigned PATTERN_CNT  = 2,
  parameter int unsigned DATA_TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_deser_valid,
  input  logic [63:0] i_deser_data,
  input  logic        i_pattern_det_en,
  output logic        o_rx_sb_pattern_samp_done,
  output logic        o_msg_valid,
  output logic        o_has_data,
  output logic [7:0]  o_msgcode,
  output logic [7:0]  o_msgsubcode,
  output logic [15:0] o_msginfo,
  output logic [63:0] o_data,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam int unsigned       IDLE_W    = $clog2(DATA_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DATA_TIMEOUT - 1);

  rx_state_t         state_q;
  logic [IDLE_W-1:0] idle_cnt_q;

  logic [7:0]  hdr_code_q, hdr_sub_q;
  logic [15:0] hdr_info_q;
  logic        hdr_dp_q;

  logic        msg_valid_q, has_data_q, err_q, busy_q;
  logic [7:0]  msgcode_q, msgsubcode_q;
  logic [15:0] msginfo_q;
  logic [63:0] data_q;
  err_code_t   err_code_q;

  logic [4:0] opc_d;
  logic       cp_ok_d, dp_ok_d, decode_d;

  assign opc_d    = i_deser_data[OPC_MSB:OPC_LSB];
  assign cp_ok_d  = hdr_cp_ok(i_deser_data);
  assign dp_ok_d  = (^i_deser_data) == hdr_dp_q;
  assign decode_d = i_deser_valid && !i_pattern_det_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      idle_cnt_q   <= '0;
      hdr_code_q   <= '0;
      hdr_sub_q    <= '0;
      hdr_info_q   <= '0;
      hdr_dp_q     <= 1'b0;
      msg_valid_q  <= 1'b0;
      has_data_q   <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      msgcode_q    <= '0;
      msgsubcode_q <= '0;
      msginfo_q    <= '0;
      data_q       <= '0;
      err_code_q   <= ERR_TIMEOUT;
    end else begin
      msg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (decode_d) begin
            if (!cp_ok_d) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CP;
            end else if (opc_d == OPC_MSG_NODATA) begin
              msg_valid_q  <= 1'b1;
              has_data_q   <= 1'b0;
              msgcode_q    <= i_deser_data[MSGCODE_MSB:MSGCODE_LSB];
              msgsubcode_q <= i_deser_data[SUBCODE_MSB:SUBCODE_LSB];
              msginfo_q    <= i_deser_data[INFO_MSB:INFO_LSB];
              data_q       <= '0;
            end else if (opc_d == OPC_MSG_DATA) begin
              hdr_code_q <= i_deser_data[MSGCODE_MSB:MSGCODE_LSB];
              hdr_sub_q  <= i_deser_data[SUBCODE_MSB:SUBCODE_LSB];
              hdr_info_q <= i_deser_data[INFO_MSB:INFO_LSB];
              hdr_dp_q   <= i_deser_data[DP_BIT];
              idle_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= WAIT_DATA;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OPC;
            end
          end
        end
        WAIT_DATA: begin
          // Pattern-detect mode aborts silently; a word arriving on the last
          // idle cycle wins over the timeout.
          if (i_pattern_det_en) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (i_deser_valid) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (dp_ok_d) begin
              msg_valid_q  <= 1'b1;
              has_data_q   <= 1'b1;
              msgcode_q    <= hdr_code_q;
              msgsubcode_q <= hdr_sub_q;
              msginfo_q    <= hdr_info_q;
              data_q       <= i_deser_data;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_DP;
            end
          end else if (idle_cnt_q == IDLE_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sb_rx_pattern_detector #(
    .PATTERN_CNT(PATTERN_CNT)
  ) u_pattern_det (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (i_pattern_det_en),
    .valid_i(i_deser_valid),
    .data_i (i_deser_data),
    .done_o (o_rx_sb_pattern_samp_done)
  );

  assign o_msg_valid  = msg_valid_q;
  assign o_has_data   = has_data_q;
  assign o_msgcode    = msgcode_q;
  assign o_msgsubcode = msgsubcode_q;
  assign o_msginfo    = msginfo_q;
  assign o_data       = data_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_sb_rx_packet_decoder.sv
// Bench for sb_rx_packet_decoder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_sb_rx_packet_decoder;

  localparam int          PC  = 2;
  localparam int          TO  = 8;
  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        pden = 1'b0;
  logic [63:0] din = '0;

  logic        o_done, o_msg_valid, o_has_data, o_err, o_busy;
  logic [7:0]  o_msgcode, o_msgsubcode;
  logic [15:0] o_msginfo;
  logic [63:0] o_data;
  logic [1:0]  o_err_code;

  int n_chk = 0;
  int n_fail = 0;

  sb_rx_packet_decoder #(
    .PATTERN_CNT (PC),
    .DATA_TIMEOUT(TO)
  ) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_deser_valid            (vld),
    .i_deser_data             (din),
    .i_pattern_det_en         (pden),
    .o_rx_sb_pattern_samp_done(o_done),
    .o_msg_valid              (o_msg_valid),
    .o_has_data               (o_has_data),
    .o_msgcode                (o_msgcode),
    .o_msgsubcode             (o_msgsubcode),
    .o_msginfo                (o_msginfo),
    .o_data                   (o_data),
    .o_err                    (o_err),
    .o_err_code               (o_err_code),
    .o_busy                   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_word(input logic [4:0] opc, input logic [7:0] code,
                                          input logic [7:0] sub, input logic [15:0] info,
                                          input logic dp, input logic cp_bad,
                                          input logic [63:0] junk);
    logic [63:0] w;
    w = junk & 64'h3F00_0000_FFC0_3FE0;
    w[4:0]   = opc;
    w[21:14] = code;
    w[39:32] = sub;
    w[55:40] = info;
    w[62]    = dp;
    w[63]    = (^w[61:0]) ^ cp_bad;
    return w;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_pend;
  logic [63:0] m_hdr;
  int          m_idle;
  int          m_run;
  logic        e_msg, e_err, e_has;
  logic [7:0]  e_code, e_sub;
  logic [15:0] e_info;
  logic [63:0] e_data;
  logic [1:0]  e_ecode;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_idle = 0; m_run = 0; m_hdr = '0;
      e_msg = 0; e_err = 0; e_has = 0; e_code = '0; e_sub = '0; e_info = '0;
      e_data = '0; e_ecode = '0;
    end else begin
      e_msg = 0;
      e_err = 0;
      if (m_pend) begin
        if (pden) begin
          m_pend = 0;
        end else if (vld) begin
          m_pend = 0;
          if ((^din) == m_hdr[62]) begin
            e_msg = 1; e_has = 1; e_data = din;
            e_code = m_hdr[21:14]; e_sub = m_hdr[39:32]; e_info = m_hdr[55:40];
          end else begin
            e_err = 1; e_ecode = 2'd2;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_pend = 0; e_err = 1; e_ecode = 2'd0;
          end
        end
      end else if (vld && !pden) begin
        if (din[63] != ^din[61:0]) begin
          e_err = 1; e_ecode = 2'd1;
        end else if (din[4:0] == 5'b10010) begin
          e_msg = 1; e_has = 0; e_data = '0;
          e_code = din[21:14]; e_sub = din[39:32]; e_info = din[55:40];
        end else if (din[4:0] == 5'b11011) begin
          m_pend = 1; m_hdr = din; m_idle = 0;
        end else begin
          e_err = 1; e_ecode = 2'd3;
        end
      end
      if (!pden) m_run = 0;
      else if (vld) m_run = (din == PAT) ? ((m_run < PC) ? m_run + 1 : PC) : 0;
    end
    #1;
    chk("msg_valid", o_msg_valid, e_msg);
    chk("err", o_err, e_err);
    chk("has_data", o_has_data, e_has);
    chk("busy", o_busy, m_pend);
    chk("pattern_done", o_done, m_run == PC);
    chk("msgcode", o_msgcode, e_code);
    chk("msgsubcode", o_msgsubcode, e_sub);
    chk("msginfo", o_msginfo, e_info);
    chk("data", o_data, e_data);
    if (e_err) chk("err_code", o_err_code, e_ecode);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [63:0] d, input logic p);
    @(negedge clk);
    vld = v; din = d; pden = p;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; vld = 1'b0; pden = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [63:0] w;
  int          busy_cycles;

  initial begin
    step(0, '0, 0);
    step(0, '0, 0);
    chk("reset_msg_valid", o_msg_valid, 0);
    chk("reset_err", o_err, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_data", o_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // pattern detect
    step(1, PAT, 1);
    chk("pat_done_w1", o_done, 0);
    step(1, 64'h0, 1);
    chk("pat_done_w2", o_done, 0);
    step(1, PAT, 1);
    step(1, PAT, 1);
    chk("pat_done_w4", o_done, 1);
    step(0, '0, 0);
    chk("pat_done_off", o_done, 0);

    // no-data message
    w = mk_word(5'b10010, 8'h85, 8'h01, 16'h1234, 1'b0, 1'b0, '0);
    step(1, w, 0);
    chk("nd_valid", o_msg_valid, 1);
    chk("nd_has_data", o_has_data, 0);
    chk("nd_msgcode", o_msgcode, 8'h85);
    chk("nd_subcode", o_msgsubcode, 8'h01);
    chk("nd_msginfo", o_msginfo, 16'h1234);
    chk("nd_data", o_data, 0);
    step(0, '0, 0);
    chk("nd_single_pulse", o_msg_valid, 0);

    // data message with 3 idle cycles
    busy_cycles = 0;
    w = mk_word(5'b11011, 8'h42, 8'h07, 16'hBEEF, 1'b0, 1'b0, '0);
    step(1, w, 0);
    busy_cycles += int'(o_busy);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0);
      busy_cycles += int'(o_busy);
    end
    step(1, 64'hFF, 0);
    busy_cycles += int'(o_busy);
    chk("dm_busy_cycles", busy_cycles, 4);
    chk("dm_valid", o_msg_valid, 1);
    chk("dm_has_data", o_has_data, 1);
    chk("dm_data", o_data, 64'hFF);
    chk("dm_msgcode", o_msgcode, 8'h42);

    // errors
    w = mk_word(5'b10010, 8'h11, 8'h22, 16'h3333, 1'b0, 1'b1, '0);
    step(1, w, 0);
    chk("cp_err", o_err, 1);
    chk("cp_code", o_err_code, 2'b01);
    chk("cp_no_msg", o_msg_valid, 0);
    w = mk_word(5'b00000, 8'h11, 8'h22, 16'h3333, 1'b0, 1'b0, '0);
    step(1, w, 0);
    chk("opc_code", o_err_code, 2'b11);
    w = mk_word(5'b11011, 8'h11, 8'h22, 16'h3333, 1'b1, 1'b0, '0);
    step(1, w, 0);
    step(1, 64'hFF, 0);
    chk("dp_err", o_err, 1);
    chk("dp_code", o_err_code, 2'b10);

    // timeout after 8 idle cycles
    w = mk_word(5'b11011, 8'h5A, 8'hA5, 16'h0F0F, 1'b0, 1'b0, '0);
    step(1, w, 0);
    for (int i = 0; i < TO - 1; i++) step(0, '0, 0);
    chk("to_not_yet", o_err, 0);
    step(0, '0, 0);
    chk("to_err", o_err, 1);
    chk("to_code", o_err_code, 2'b00);
    chk("to_busy", o_busy, 0);

    // data arriving on idle cycle 8 wins
    step(1, w, 0);
    for (int i = 0; i < TO - 1; i++) step(0, '0, 0);
    step(1, 64'h3, 0);
    chk("to_edge_valid", o_msg_valid, 1);
    chk("to_edge_err", o_err, 0);
    chk("to_edge_data", o_data, 64'h3);

    // async reset mid-packet
    step(1, w, 0);
    step(0, '0, 0);
    @(negedge clk);
    rst_n = 1'b0; vld = 1'b0;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_msgcode", o_msgcode, 0);
    chk("rst_data", o_data, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    w = mk_word(5'b10010, 8'h33, 8'h44, 16'h5566, 1'b1, 1'b0, '0);
    step(1, w, 0);
    chk("post_rst_valid", o_msg_valid, 1);
    chk("post_rst_info", o_msginfo, 16'h5566);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        v, p;
      int unsigned k;
      logic [63:0] d;
      if (i % 1000 == 999) pulse_reset();
      p = pden;
      if ($urandom_range(0, 99) < 4) p = ~p;
      v = ($urandom_range(0, 99) < 65);
      k = $urandom_range(0, 9);
      if (p) begin
        d = (k < 7) ? PAT : {$urandom, $urandom};
      end else begin
        case (k)
          0, 1, 2: d = mk_word(5'b10010, 8'($urandom), 8'($urandom), 16'($urandom),
                               1'($urandom), 1'b0, {$urandom, $urandom});
          3, 4, 5: d = mk_word(5'b11011, 8'($urandom), 8'($urandom), 16'($urandom),
                               1'($urandom), 1'b0, {$urandom, $urandom});
          6:       d = mk_word(5'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                               1'($urandom), 1'($urandom), {$urandom, $urandom});
          default: d = {$urandom, $urandom};
        endcase
      end
      step(v, d, p);
    end

    step(0, '0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
